// File: rtl/mul_man_pipe.sv
// Pipelined unsigned mantissa multiplier with normalization and G/R/S rounding decision.
// Define MUL_MAN_PIPE_RNE_EN for round-to-nearest-even; otherwise ties truncate.
module mul_man_pipe #(
    parameter int SIZE_DATA = 24,
    parameter int STAGES    = 3,
    parameter int TAG_W     = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [SIZE_DATA-1:0] i_data_a,
    input  logic [SIZE_DATA-1:0] i_data_b,
    input  logic [TAG_W-1:0]     i_tag,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [SIZE_DATA-1:0] o_data_mul,
    output logic                 o_norm_shift,
    output logic                 o_round_up,
    output logic                 o_zero,
    output logic [TAG_W-1:0]     o_tag
);

    localparam int W  = SIZE_DATA;
    localparam int PW = 2 * W;
    localparam int PD = (STAGES > 1) ? STAGES - 1 : 1;

    logic                 w_en;
    logic [PW-1:0]        w_prod;
    logic [PW-1:0]        w_pn;
    logic                 w_vn;
    logic [TAG_W-1:0]     w_tn;
    logic [W-1:0]         w_mant;
    logic                 w_norm;
    logic                 w_g;
    logic                 w_r;
    logic                 w_s;
    logic                 w_rnd;
    logic                 w_zero;

    logic [PW-1:0]        r_p   [PD];
    logic [TAG_W-1:0]     r_pt  [PD];
    logic [PD-1:0]        r_pv;

    logic                 r_ov;
    logic [W-1:0]         r_mant;
    logic                 r_norm;
    logic                 r_rnd;
    logic                 r_zero;
    logic [TAG_W-1:0]     r_otag;

    assign w_en    = ~r_ov | i_ready;
    assign o_ready = w_en;
    assign w_prod  = {{W{1'b0}}, i_data_a} * {{W{1'b0}}, i_data_b};

    // With a single stage the output register sees the raw product directly.
    generate
        if (STAGES == 1) begin : g_direct
            assign w_pn = w_prod;
            assign w_vn = i_valid;
            assign w_tn = i_tag;
        end else begin : g_piped
            assign w_pn = r_p[PD-1];
            assign w_vn = r_pv[PD-1];
            assign w_tn = r_pt[PD-1];
        end
    endgenerate

    always_comb begin
        w_norm = w_pn[PW-1];
        w_mant = w_pn[PW-2:W-1];
        w_g    = w_pn[W-2];
        w_r    = w_pn[W-3];
        w_s    = |w_pn[W-4:0];
        if (w_norm) begin
            w_mant = w_pn[PW-1:W];
            w_g    = w_pn[W-1];
            w_r    = w_pn[W-2];
            w_s    = |w_pn[W-3:0];
        end
        w_zero = (w_pn == '0);
`ifdef MUL_MAN_PIPE_RNE_EN
        w_rnd  = w_g & (w_r | w_s | w_mant[0]);
`else
        w_rnd  = w_g & (w_r | w_s);
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < PD; i++) begin
                r_p[i]  <= '0;
                r_pt[i] <= '0;
            end
            r_pv <= '0;
        end else if (w_en) begin
            r_p[0]  <= w_prod;
            r_pt[0] <= i_tag;
            r_pv[0] <= i_valid;
            for (int i = 1; i < PD; i++) begin
                r_p[i]  <= r_p[i-1];
                r_pt[i] <= r_pt[i-1];
                r_pv[i] <= r_pv[i-1];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ov   <= 1'b0;
            r_mant <= '0;
            r_norm <= 1'b0;
            r_rnd  <= 1'b0;
            r_zero <= 1'b0;
            r_otag <= '0;
        end else if (w_en) begin
            r_ov   <= w_vn;
            r_mant <= w_mant;
            r_norm <= w_norm;
            r_rnd  <= w_rnd;
            r_zero <= w_zero;
            r_otag <= w_tn;
        end
    end

    assign o_valid      = r_ov;
    assign o_data_mul   = r_mant;
    assign o_norm_shift = r_norm;
    assign o_round_up   = r_rnd;
    assign o_zero       = r_zero;
    assign o_tag        = r_otag;

endmodule

// File: tb/tb_mul_man_pipe.sv
// Directed self-checking bench for mul_man_pipe (W=24, STAGES=3, TAG_W=4).
// Covers latency, normalization, rounding, zero, stall/hold, and mid-flight reset.
module tb_mul_man_pipe;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [23:0] i_data_a;
    logic [23:0] i_data_b;
    logic [3:0]  i_tag;
    logic        o_valid;
    logic        i_ready;
    logic [23:0] o_data_mul;
    logic        o_norm_shift;
    logic        o_round_up;
    logic        o_zero;
    logic [3:0]  o_tag;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    mul_man_pipe #(.SIZE_DATA(24), .STAGES(3), .TAG_W(4)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_data_a     (i_data_a),
        .i_data_b     (i_data_b),
        .i_tag        (i_tag),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data_mul   (o_data_mul),
        .o_norm_shift (o_norm_shift),
        .o_round_up   (o_round_up),
        .o_zero       (o_zero),
        .o_tag        (o_tag)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One isolated op: accepted at edge N, visible after edge N+2.
    task automatic run_one(input string nm, input logic [23:0] a,
                           input logic [23:0] b, input logic [3:0] t,
                           input logic [23:0] em, input logic en,
                           input logic er, input logic ez);
        @(negedge i_clk);
        i_valid  = 1'b1;
        i_data_a = a;
        i_data_b = b;
        i_tag    = t;
        #1 chk({nm, "_ready"}, o_ready, 1);
        @(negedge i_clk);
        i_valid = 1'b0;
        chk({nm, "_lat1"}, o_valid, 0);
        @(negedge i_clk);
        chk({nm, "_lat2"}, o_valid, 0);
        @(negedge i_clk);
        chk({nm, "_valid"}, o_valid, 1);
        chk({nm, "_mant"}, o_data_mul, em);
        chk({nm, "_norm"}, o_norm_shift, en);
        chk({nm, "_rnd"}, o_round_up, er);
        chk({nm, "_zero"}, o_zero, ez);
        chk({nm, "_tag"}, o_tag, t);
    endtask

    initial begin
        int          sent;
        int          rcv;
        int          stall;
        int          cyc;
        logic        exp_en;
        logic        rne;
        logic [23:0] hold_d;
        logic [3:0]  hold_t;

`ifdef MUL_MAN_PIPE_RNE_EN
        rne = 1'b1;
`else
        rne = 1'b0;
`endif
        i_rst_n  = 1'b1;
        i_valid  = 1'b0;
        i_ready  = 1'b1;
        i_data_a = '0;
        i_data_b = '0;
        i_tag    = '0;
        hold_d   = '0;
        hold_t   = '0;
        #2 i_rst_n = 1'b0;
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_mant", o_data_mul, 0);
        chk("rst_norm", o_norm_shift, 0);
        chk("rst_rnd", o_round_up, 0);
        chk("rst_zero", o_zero, 0);
        chk("rst_tag", o_tag, 0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        #1 chk("rst_ready", o_ready, 1);

        run_one("one", 24'h800000, 24'h800000, 4'h5, 24'h800000, 0, 0, 0);
        run_one("max", 24'hFFFFFF, 24'hFFFFFF, 4'h6, 24'hFFFFFE, 1, 0, 0);
        run_one("tie", 24'h800001, 24'hC00000, 4'h7, 24'hC00001, 0, rne, 0);
        run_one("nrm", 24'hC00000, 24'hC00000, 4'h8, 24'h900000, 1, 0, 0);
        run_one("zer", 24'h000000, 24'h9ABCDE, 4'h9, 24'h000000, 0, 0, 1);

        // Streaming 8 ops with a two-cycle output stall after the third result.
        sent  = 0;
        rcv   = 0;
        stall = 0;
        cyc   = 0;
        while (rcv < 8 && cyc < 60) begin
            @(negedge i_clk);
            cyc++;
            i_ready = !(rcv == 3 && stall < 2);
            if (sent < 8) begin
                i_valid  = 1'b1;
                i_data_a = 24'h800000 + 24'(sent);
                i_data_b = 24'h800000;
                i_tag    = 4'(sent);
            end else begin
                i_valid = 1'b0;
            end
            #1;
            exp_en = !o_valid || i_ready;
            chk("str_ready", o_ready, exp_en);
            if (!i_ready) begin
                chk("stall_valid", o_valid, 1);
                if (stall == 1) begin
                    chk("hold_mant", o_data_mul, hold_d);
                    chk("hold_tag", o_tag, hold_t);
                end
                hold_d = o_data_mul;
                hold_t = o_tag;
                stall++;
            end
            if (o_valid && i_ready) begin
                chk("str_mant", o_data_mul, 24'h800000 + 24'(rcv));
                chk("str_tag", o_tag, 4'(rcv));
                rcv++;
            end
            if (i_valid && exp_en) sent++;
        end
        chk("str_count", rcv, 8);
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (3) @(negedge i_clk);

        // Reset with three ops in flight.
        for (int k = 1; k <= 3; k++) begin
            @(negedge i_clk);
            i_valid  = 1'b1;
            i_data_a = 24'h800000;
            i_data_b = 24'h800000;
            i_tag    = 4'(k);
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        #1 chk("fly_valid", o_valid, 1);
        #1 i_rst_n = 1'b0;
        #1;
        chk("mrst_valid", o_valid, 0);
        chk("mrst_mant", o_data_mul, 0);
        chk("mrst_tag", o_tag, 0);
        chk("mrst_norm", o_norm_shift, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1 chk("rel_ready", o_ready, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            chk("no_stale", o_valid, 0);
        end
        run_one("post", 24'hFFFFFF, 24'hFFFFFF, 4'hA, 24'hFFFFFE, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
